// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC / ROM fetch sequencer presenting one instruction at a time
//            to the control FSM; stops on the HALT opcode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int         ADDR_W  = 6,
  parameter int         INSTR_W = 10,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               done,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  br_add,
  input  logic               bxlr,
  input  logic [ADDR_W-1:0]  bus_in,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [7:0]         retired
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_exec  = 3'd3;
  localparam logic [2:0] c_st_halt  = 3'd4;

  localparam logic [ADDR_W-1:0] c_pc_one  = ADDR_W'(1);
  localparam logic [7:0]        c_ret_max = 8'hFF;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [7:0]         r_retired;
  logic               w_event;
  logic               w_retire;
  logic               w_is_halt;

  assign w_event   = done | branch | bxlr;
  assign w_retire  = (r_state == c_st_exec) && w_event;
  assign w_is_halt = (rom_data[INSTR_W-1 -: 4] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (run) w_next_state = c_st_fetch;
      c_st_fetch: w_next_state = c_st_wait;
      c_st_wait:  w_next_state = w_is_halt ? c_st_halt : c_st_exec;
      c_st_exec:  if (w_event) w_next_state = c_st_fetch;
      c_st_halt:  w_next_state = c_st_halt;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    rom_en      = (r_state == c_st_fetch);
    instr_valid = (r_state == c_st_exec);
    halted      = (r_state == c_st_halt);
  end

  // Only the highest-priority event moves the PC: bxlr, then branch, then done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == c_st_wait) begin
        r_instr <= rom_data;
      end
      if (w_retire) begin
        if (bxlr) begin
          r_pc <= bus_in;
        end else if (branch) begin
          r_pc <= br_add;
        end else begin
          r_pc <= r_pc + c_pc_one;
        end
        if (r_retired != c_ret_max) begin
          r_retired <= r_retired + 8'd1;
        end
      end
    end
  end

  assign pc          = r_pc;
  assign rom_addr    = r_pc;
  assign instruction = r_instr;
  assign retired     = r_retired;

endmodule
`default_nettype wire
